sprite_plotter: RTL
===================

Name: sprite_plotter

Overview:
Downstream consumer of the sprite character counter. It walks a small sprite ROM pixel by pixel and offsets each pixel by a latched screen position. It emits one VGA adapter write strobe per visible, non-transparent pixel. It sits between the sprite ROM and the VGA adapter's plot/x/y/colour inputs, and reports busy/done to the game FSM.

Parameters:
SPR_W, 5, sprite width in pixels
SPR_H, 5, sprite height in pixels
ADDR_W, 5, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H
COLOR_W, 8, ROM data / colour width
X_W, 8, screen x coordinate width
Y_W, 7, screen y coordinate width
SCREEN_W, 160, visible columns; x >= SCREEN_W is clipped
SCREEN_H, 120, visible rows; y >= SCREEN_H is clipped
TRANSP_EN, 1, 1 = pixels equal to TRANSP_COLOR are not plotted
TRANSP_COLOR, 0, transparent colour key

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to draw; sampled only when not busy
base_x  in  X_W  screen x of sprite top-left; latched on accepted start
base_y  in  Y_W  screen y of sprite top-left; latched on accepted start
rom_addr  out  ADDR_W  sprite ROM address, registered
rom_data  in  COLOR_W  sprite ROM output; synchronous ROM, valid 1 cycle after rom_addr
plot  out  1  VGA write strobe, registered
x_out  out  X_W  pixel x, registered
y_out  out  Y_W  pixel y, registered
colour  out  COLOR_W  pixel colour, registered
busy  out  1  high while a sprite is in flight
done  out  1  one-cycle pulse after the last pixel slot

Behaviour:
- Reset (sync, active-high, highest priority): state IDLE; rom_addr, plot, x_out, y_out, colour, busy, done all 0; col/row counters and pipeline valids cleared. Mid-draw reset aborts the draw with no done pulse; remaining pixels are never plotted.
- States: IDLE -> FETCH (on start while !busy) -> DRAIN (after last address issued) -> IDLE (done pulse).
- Start accepted in cycle 0. At that edge base_x/base_y are latched, rom_addr<=0, col<=0, row<=0, busy<=1.
- FETCH: rom_addr = k for pixel k = row*SPR_W+col in cycles 1..N, where N = SPR_W*SPR_H. Address is a running +1 counter (no multiplier). col wraps SPR_W-1 -> 0 with row+1.
- Stage-1 pipeline register carries valid, col, row alongside the address, aligned so that rom_data for pixel k is paired with its col/row in cycle k+2.
- Output stage, registered at end of cycle k+2, visible in cycle k+3:
  - x_out = base_x+col, truncated to X_W; y_out = base_y+row, truncated to Y_W; colour = rom_data.
  - Sums are computed at X_W+1 / Y_W+1 bits.
  - plot = valid AND (x_sum < SCREEN_W) AND (y_sum < SCREEN_H) AND NOT(TRANSP_EN AND rom_data == TRANSP_COLOR).
  - x_out/y_out/colour update for every valid slot, plotted or not. They hold their value when there is no valid slot.
- Latency: first plot slot is cycle 3; last slot is cycle N+2. done=1 and busy=0 in cycle N+3. busy is high in cycles 1..N+2.
- start while busy is ignored. Base latches do not change. start in the done cycle (busy=0) is accepted normally, giving back-to-back sprites with one bubble cycle.
- Clipping is per pixel, with no wrap: x_sum=160 is suppressed, never plotted at x=0.
- plot is never high outside cycles 3..N+2 of a draw.

Test Plan:
- Opaque draw: ROM[k]=k+1, start with base (10,20) -> plot high cycles 3..27 (25 plots); cycle 3 (10,20) colour 1; cycle 27 (14,24) colour 25; done in cycle 28 only; busy cycles 1..27.
- Transparency: ROM[6]=0, all others nonzero, TRANSP_EN=1 -> plot low in cycle 9 only (x_out=11, y_out=21); 24 plots total.
- Clipping: base (157,118) -> only col 0..2 and row 0..1 plotted = 6 plots; (160,118) and (157,120) never strobed; done still in cycle 28.
- Busy/back-to-back: start again in cycle 5 with base (0,0) -> ignored, all outputs unchanged. Start in cycle 28 with base (0,0) -> second draw plots (0,0) in cycle 31.
- Reset mid-draw: reset in cycle 10 -> in cycle 11 all outputs 0, busy 0, and no done pulse ever. A start in cycle 12 draws normally with done in cycle 40.
- Reset during the idle cycle after done: outputs stay 0; start ignored only in the reset cycle itself.

Source files
------------

// File: rtl/sprite_plotter_if.sv
// Sprite plotter bus: draw request, sprite ROM port and VGA adapter pixel outputs.
interface sprite_plotter_if #(
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned COLOR_W = 8,
   parameter int unsigned X_W     = 8,
   parameter int unsigned Y_W     = 7
);
   logic               start;
   logic [X_W-1:0]     base_x;
   logic [Y_W-1:0]     base_y;
   logic [ADDR_W-1:0]  rom_addr;
   logic [COLOR_W-1:0] rom_data;
   logic               plot;
   logic [X_W-1:0]     x_out;
   logic [Y_W-1:0]     y_out;
   logic [COLOR_W-1:0] colour;
   logic               busy;
   logic               done;

   modport slave (
      input  start, base_x, base_y, rom_data,
      output rom_addr, plot, x_out, y_out, colour, busy, done
   );

   modport master (
      output start, base_x, base_y, rom_data,
      input  rom_addr, plot, x_out, y_out, colour, busy, done
   );
endinterface

// File: rtl/sprite_plotter.sv
// Walks the sprite ROM pixel by pixel and emits clipped, colour-keyed VGA write strobes
// offset by a screen position latched at start.
module sprite_plotter #(
   parameter int unsigned        SPR_W        = 5,
   parameter int unsigned        SPR_H        = 5,
   parameter int unsigned        ADDR_W       = 5,
   parameter int unsigned        COLOR_W      = 8,
   parameter int unsigned        X_W          = 8,
   parameter int unsigned        Y_W          = 7,
   parameter int unsigned        SCREEN_W     = 160,
   parameter int unsigned        SCREEN_H     = 120,
   parameter bit                 TRANSP_EN    = 1'b1,
   parameter logic [COLOR_W-1:0] TRANSP_COLOR = '0
) (
   input logic              clk,
   input logic              reset,
   sprite_plotter_if.slave  bus
);
   localparam int unsigned N  = SPR_W * SPR_H;
   localparam int unsigned CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
   localparam int unsigned RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t             state_q;
   logic [X_W-1:0]     base_x_q;
   logic [Y_W-1:0]     base_y_q;
   logic [ADDR_W-1:0]  rom_addr_q;
   logic [CW-1:0]      col_q, s1_col_q;
   logic [RW-1:0]      row_q, s1_row_q;
   logic               s1_valid_q;
   logic               plot_q, busy_q, done_q;
   logic [X_W-1:0]     x_out_q;
   logic [Y_W-1:0]     y_out_q;
   logic [COLOR_W-1:0] colour_q;

   logic [X_W:0]       x_sum_d;
   logic [Y_W:0]       y_sum_d;
   logic               plot_d;

   // One extra bit on the sums so off-screen pixels are dropped instead of wrapping to x/y = 0.
   always_comb begin
      x_sum_d = {1'b0, base_x_q} + (X_W+1)'(s1_col_q);
      y_sum_d = {1'b0, base_y_q} + (Y_W+1)'(s1_row_q);
      plot_d  = s1_valid_q
             && (x_sum_d < (X_W+1)'(SCREEN_W))
             && (y_sum_d < (Y_W+1)'(SCREEN_H))
             && !(TRANSP_EN && (bus.rom_data == TRANSP_COLOR));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         base_x_q   <= '0;
         base_y_q   <= '0;
         rom_addr_q <= '0;
         col_q      <= '0;
         row_q      <= '0;
         s1_valid_q <= 1'b0;
         s1_col_q   <= '0;
         s1_row_q   <= '0;
         plot_q     <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         x_out_q    <= '0;
         y_out_q    <= '0;
         colour_q   <= '0;
      end else begin
         done_q     <= 1'b0;
         plot_q     <= plot_d;
         // Stage 1 tracks the address in flight so col/row meet rom_data one cycle later.
         s1_valid_q <= (state_q == FETCH);
         s1_col_q   <= col_q;
         s1_row_q   <= row_q;
         if (s1_valid_q) begin
            x_out_q  <= x_sum_d[X_W-1:0];
            y_out_q  <= y_sum_d[Y_W-1:0];
            colour_q <= bus.rom_data;
         end

         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  base_x_q   <= bus.base_x;
                  base_y_q   <= bus.base_y;
                  rom_addr_q <= '0;
                  col_q      <= '0;
                  row_q      <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= FETCH;
               end
            end
            FETCH: begin
               if (rom_addr_q == ADDR_W'(N - 1)) begin
                  state_q <= DRAIN;
               end else begin
                  rom_addr_q <= rom_addr_q + ADDR_W'(1);
                  if (col_q == CW'(SPR_W - 1)) begin
                     col_q <= '0;
                     row_q <= row_q + RW'(1);
                  end else begin
                     col_q <= col_q + CW'(1);
                  end
               end
            end
            DRAIN: begin
               // Stage 1 empty means the last pixel has just been registered at the output.
               if (!s1_valid_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.rom_addr = rom_addr_q;
   assign bus.plot     = plot_q;
   assign bus.x_out    = x_out_q;
   assign bus.y_out    = y_out_q;
   assign bus.colour   = colour_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule
